// File: rtl/ysyx_22050598_ifu.sv
// Instruction fetch unit: holds the PC, issues one imem request at a time and
// presents each fetched word with its PC through a one-entry valid/ready register.
module ysyx_22050598_ifu #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [63:0] out_pc,
   output logic        out_misalign
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        drop_q, drop_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic [63:0] out_pc_q, out_pc_d;
   logic        out_misalign_q, out_misalign_d;
   logic        aligned_s;
   logic        req_fire_s;

   assign aligned_s      = (pc_q[1:0] == 2'b00);
   assign imem_req_valid = (state_q == ST_REQ) && aligned_s;
   assign req_fire_s     = imem_req_valid && imem_req_ready;
   assign imem_addr      = pc_q;
   assign out_valid      = out_valid_q;
   assign out_inst       = out_inst_q;
   assign out_pc         = out_pc_q;
   assign out_misalign   = out_misalign_q;

   // Next-state logic; a redirect overrides every other event in its cycle.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      drop_d         = drop_q;
      out_valid_d    = out_valid_q;
      out_inst_d     = out_inst_q;
      out_pc_d       = out_pc_q;
      out_misalign_d = out_misalign_q;
      case (state_q)
         ST_REQ: begin
            if (redirect_valid) begin
               pc_d        = redirect_pc;
               out_valid_d = 1'b0;
               if (req_fire_s) begin
                  state_d = ST_WAIT;
                  drop_d  = 1'b1;
               end else begin
                  state_d = ST_REQ;
               end
            end else if (!aligned_s) begin
               out_inst_d     = 32'd0;
               out_pc_d       = pc_q;
               out_misalign_d = 1'b1;
               out_valid_d    = 1'b1;
               state_d        = ST_HOLD;
            end else if (req_fire_s) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               pc_d        = redirect_pc;
               out_valid_d = 1'b0;
               if (imem_resp_valid) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  drop_d  = 1'b1;
               end
            end else if (imem_resp_valid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  out_inst_d     = imem_resp_data;
                  out_pc_d       = pc_q;
                  out_misalign_d = 1'b0;
                  out_valid_d    = 1'b1;
                  state_d        = ST_HOLD;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               pc_d        = redirect_pc;
               out_valid_d = 1'b0;
               state_d     = ST_REQ;
            end else if (out_ready) begin
               pc_d        = pc_q + 64'd4;
               out_valid_d = 1'b0;
               state_d     = ST_REQ;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d     = ST_REQ;
            drop_d      = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State, PC and output-register flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_REQ;
         pc_q           <= RESET_PC;
         drop_q         <= 1'b0;
         out_valid_q    <= 1'b0;
         out_inst_q     <= 32'd0;
         out_pc_q       <= 64'd0;
         out_misalign_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         drop_q         <= drop_d;
         out_valid_q    <= out_valid_d;
         out_inst_q     <= out_inst_d;
         out_pc_q       <= out_pc_d;
         out_misalign_q <= out_misalign_d;
      end
   end

endmodule

// File: tb/tb_ysyx_22050598_ifu.sv
// Directed self-checking bench for ysyx_22050598_ifu; the bench plays the memory
// and decode stage by hand, cycle by cycle.
module tb_ysyx_22050598_ifu;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [63:0] out_pc;
   logic        out_misalign;

   int errors = 0;
   int checks = 0;

   ysyx_22050598_ifu dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_pc(out_pc), .out_misalign(out_misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
      redirect_valid = 1'b0; redirect_pc = 64'd0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_out_mis", {63'd0, out_misalign}, 64'd0);
      rst = 1'b0;
      chk("first_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("first_req_addr", imem_addr, 64'h8000_0000);

      // zero-wait fetch of 0x13
      imem_req_ready = 1'b1; tick();
      chk("wait_no_req", {63'd0, imem_req_valid}, 64'd0);
      imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013; tick();
      imem_resp_valid = 1'b0;
      chk("f1_valid", {63'd0, out_valid}, 64'd1);
      chk("f1_pc", out_pc, 64'h8000_0000);
      chk("f1_inst", {32'd0, out_inst}, 64'h13);

      // backpressure for 5 cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_inst", {32'd0, out_inst}, 64'h13);
         chk("bp_pc", out_pc, 64'h8000_0000);
         chk("bp_no_req", {63'd0, imem_req_valid}, 64'd0);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("adv_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("adv_addr", imem_addr, 64'h8000_0004);
      chk("adv_out_valid", {63'd0, out_valid}, 64'd0);

      // fetch 0x80000004
      imem_req_ready = 1'b1; tick();
      imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093; tick();
      imem_resp_valid = 1'b0;
      chk("f2_pc", out_pc, 64'h8000_0004);
      chk("f2_inst", {32'd0, out_inst}, 64'h0010_0093);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("f3_addr", imem_addr, 64'h8000_0008);

      // redirect in the cycle the request for 0x80000008 is accepted
      imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_1000; tick();
      imem_req_ready = 1'b0; redirect_valid = 1'b0;
      chk("rd_wait_no_req", {63'd0, imem_req_valid}, 64'd0);
      tick(); tick();
      imem_resp_valid = 1'b1; imem_resp_data = 32'hdead_beef; tick();
      imem_resp_valid = 1'b0;
      chk("rd_drop_valid", {63'd0, out_valid}, 64'd0);
      chk("rd_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("rd_addr", imem_addr, 64'h8000_1000);

      // fetch 0x80001000 then redirect during HOLD with out_ready high
      imem_req_ready = 1'b1; tick();
      imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0073; tick();
      imem_resp_valid = 1'b0;
      chk("f4_pc", out_pc, 64'h8000_1000);
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_2000; tick();
      out_ready = 1'b0; redirect_valid = 1'b0;
      chk("hold_rd_valid", {63'd0, out_valid}, 64'd0);
      chk("hold_rd_addr", imem_addr, 64'h8000_2000);

      // back-to-back redirects while waiting; latest wins, one response dropped
      imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_3000; tick();
      redirect_pc = 64'h8000_4000; tick();
      redirect_valid = 1'b0;
      chk("b2b_no_req", {63'd0, imem_req_valid}, 64'd0);
      imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111; tick();
      imem_resp_valid = 1'b0;
      chk("b2b_valid", {63'd0, out_valid}, 64'd0);
      chk("b2b_req", {63'd0, imem_req_valid}, 64'd1);
      chk("b2b_addr", imem_addr, 64'h8000_4000);

      // redirect to a misaligned target
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0002; tick();
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      chk("mis_no_req", {63'd0, imem_req_valid}, 64'd0);
      tick(); imem_req_ready = 1'b0;
      chk("mis_valid", {63'd0, out_valid}, 64'd1);
      chk("mis_flag", {63'd0, out_misalign}, 64'd1);
      chk("mis_inst", {32'd0, out_inst}, 64'd0);
      chk("mis_pc", out_pc, 64'h8000_0002);

      // PC wraparound from the top of the address space
      redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; tick();
      redirect_valid = 1'b0;
      chk("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      imem_req_ready = 1'b1; tick();
      imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013; tick();
      imem_resp_valid = 1'b0;
      chk("top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("top_mis", {63'd0, out_misalign}, 64'd0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("wrap_addr", imem_addr, 64'd0);

      // asynchronous reset pulse mid-WAIT
      imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
      chk("pre_rst_no_req", {63'd0, imem_req_valid}, 64'd0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_req", {63'd0, imem_req_valid}, 64'd1);
      chk("async_rst_addr", imem_addr, 64'h8000_0000);
      rst = 1'b0;
      tick();
      chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("post_rst_req", {63'd0, imem_req_valid}, 64'd1);
      chk("post_rst_addr", imem_addr, 64'h8000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_22050598_ifu.md
# ysyx_22050598_ifu

Instruction fetch unit for the RV64 core: holds the 64-bit PC, issues one instruction-memory request at a time, and delivers each 32-bit instruction with its PC through a one-entry valid/ready output register to the decode stage. It handles control-flow redirects from execute at any point in a fetch, discarding stale responses. It also flags misaligned fetch targets without issuing a memory request.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  64  fetch address; equals current PC.
- imem_resp_valid  input  1  response data valid; exactly one per accepted request, ≥1 cycle after acceptance.
- imem_resp_data  input  32  fetched instruction word.
- redirect_valid  input  1  branch/jump/trap redirect from execute.
- redirect_pc  input  64  redirect target.
- out_valid  output  1  instruction register holds a valid entry.
- out_ready  input  1  decode consumes the entry this cycle.
- out_inst  output  32  instruction word to decode.
- out_pc  output  64  PC of out_inst.
- out_misalign  output  1  entry is a misaligned-fetch marker; out_inst = 0.

## Operation
- State: `pc[63:0]`, `state ∈ {REQ, WAIT, HOLD}`, `drop` (1 bit), output register `{out_inst, out_pc, out_misalign}`.
- REQ:
  - imem_req_valid = 1 when pc[1:0] == 0.
  - On imem_req_ready, go to WAIT.
  - If pc[1:0] != 0: no request; load the output register with inst = 0, pc = pc, misalign = 1; go to HOLD.
- WAIT:
  - On imem_resp_valid with drop = 0: capture resp_data and pc (misalign = 0), set out_valid, go to HOLD.
  - On imem_resp_valid with drop = 1: discard the word, clear drop, go to REQ.
- HOLD:
  - out_valid = 1.
  - On out_ready: pc ← pc + 4 (mod 2^64), clear out_valid, go to REQ.
- Redirect has priority over every other event in the same cycle:
  - pc ← redirect_pc and out_valid ← 0.
  - REQ, request not accepted this cycle: stay in REQ; imem_addr takes the new PC next cycle. This is the only case where the address may change while a request is unaccepted.
  - REQ, request accepted this cycle: go to WAIT with drop ← 1.
  - WAIT, no response this cycle: stay in WAIT with drop ← 1.
  - WAIT, response this cycle: discard it, drop ← 0, go to REQ.
  - HOLD: discard the entry (out_ready ignored), go to REQ.
- At most one request is outstanding. imem_req_valid = 0 in WAIT and HOLD.
- imem_addr = pc in all states; it is only meaningful while imem_req_valid = 1.

## Timing
- Reset values: state = REQ, pc = RESET_PC, drop = 0, out_valid = 0, out_inst = 0, out_pc = 0, out_misalign = 0.
- imem_req_valid is asserted in the first cycle after reset deassertion (combinational from state).
- Response in cycle N (drop = 0, no redirect) → out_valid = 1 in cycle N+1.
- Handshake in cycle M (out_valid & out_ready) → next request for pc + 4 in cycle M+1.
- Zero-wait memory gives throughput of one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect in cycle R:
  - imem_addr = redirect_pc from cycle R+1 when no request is in flight.
  - Otherwise the request for redirect_pc is issued the cycle after the stale response is dropped.
- out_* fields are stable while out_valid = 1 and out_ready = 0.
- Redirects back-to-back: the latest redirect_pc wins. drop stays 1 until exactly one response has been discarded.
- Reset asserted mid-fetch immediately returns all state to reset values. The memory is reset by the same rst, so no in-flight response survives.

## Test plan
- Reset then zero-wait memory returning 0x00000013: first request at addr 0x80000000; out_valid=1 with out_pc=0x80000000, out_inst=0x00000013; next request at 0x80000004.
- Decode backpressure (out_ready=0 for 5 cycles): out_valid, out_inst, out_pc held constant; no new request; on out_ready=1 the next request is for pc+4.
- Redirect to 0x80001000 in the same cycle a request for 0x80000008 is accepted, response 3 cycles later: that response is discarded (out_valid stays 0); next request at 0x80001000.
- Redirect during HOLD with out_ready=1 in the same cycle: entry discarded, pc = redirect_pc, no pc+4 advance.
- Redirect to 0x80000002: no imem request; out_valid=1, out_misalign=1, out_inst=0, out_pc=0x80000002.
- pc = 0xFFFFFFFFFFFFFFFC consumed: next request at 0x0000000000000000. Async rst pulse mid-WAIT: next cycle state = REQ, pc = RESET_PC, out_valid = 0.
